// File: rtl/dvsd_arb8.sv
// ---------------------------------------------------------------------------
// dvsd_arb8 -- 8-requester grant arbiter with hold limit
//
// Purpose:
//   Grants one of eight level-held requesters at a time. A grant is held
//   until the owner strobes done, drops its request, the arbiter is
//   disabled, or the hold counter reaches HOLD_MAX. Every release passes
//   through a one-cycle RELEASE state followed by at least one IDLE cycle.
//
// Configuration:
//   DVSD_ARB_RR_EN  defined   -> round-robin arbitration. The search starts
//                                one below the last-granted index, goes
//                                downward and wraps from 0 to 7.
//                   undefined -> fixed priority, highest index wins.
//
// Parameters:
//   HOLD_MAX  1..255  maximum consecutive cycles a grant is held
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   en      in   1  enable; 0 blocks new grants and releases a held grant
//   req     in   8  request lines, one per requester
//   done    in   1  release strobe from the owner, sampled only in GRANT
//   gnt     out  8  one-hot grant, registered
//   gnt_id  out  3  index of the granted requester, 0 when no grant
//   gs      out  1  high exactly when gnt is non-zero
//   busy    out  1  high in GRANT and RELEASE
//   tmo     out  1  one-cycle pulse when the hold limit forces a release
// ---------------------------------------------------------------------------
module dvsd_arb8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gs,
  output logic       busy,
  output logic       tmo
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gs_q, gs_d;
  logic       tmo_q, tmo_d;
  logic [7:0] hold_q, hold_d;
  // Low for the first edge after reset so a grant can never land on the
  // very first rising edge following deassertion.
  logic       rdy_q;

  logic [2:0] win_id;
  logic       grant_start;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef DVSD_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] rr_idx;

  // Walk from ptr+0 (lowest priority) up to ptr-1 (highest priority);
  // the last hit in the walk wins, so ptr-1 beats everything and the
  // last-granted requester only wins if nobody else asks.
  always_comb begin
    win_id = ptr_q;
    rr_idx = ptr_q;
    for (int k = 8; k >= 1; k--) begin
      rr_idx = ptr_q - 3'(k);
      if (req[rr_idx]) begin
        win_id = rr_idx;
      end
    end
  end
`else
  // Fixed priority: later (higher) indices overwrite earlier ones.
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        win_id = 3'(i);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Shared conditions
  // -------------------------------------------------------------------------
  assign grant_start = (state_q == ST_IDLE) && en && (|req) && rdy_q;
  assign owner_req   = req[gnt_id_q];
  assign hold_hit    = (hold_q == HOLD_LIM);
  assign release_now = done || !owner_req || !en || hold_hit;

  // -------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 8'h00;
      gnt_id_q <= 3'd0;
      gs_q     <= 1'b0;
      tmo_q    <= 1'b0;
      hold_q   <= 8'h00;
      rdy_q    <= 1'b0;
`ifdef DVSD_ARB_RR_EN
      ptr_q    <= 3'd7;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      gs_q     <= gs_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      rdy_q    <= 1'b1;
`ifdef DVSD_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:    state_d = grant_start ? ST_GRANT : ST_IDLE;
      ST_GRANT:   state_d = release_now ? ST_RELEASE : ST_GRANT;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_d    = 8'h00;
    gnt_id_d = 3'd0;
    gs_d     = 1'b0;
    tmo_d    = 1'b0;
    hold_d   = hold_q;
`ifdef DVSD_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_start) begin
          gnt_d    = 8'h01 << win_id;
          gnt_id_d = win_id;
          gs_d     = 1'b1;
          hold_d   = 8'd1;
`ifdef DVSD_ARB_RR_EN
          ptr_d    = win_id;
`endif
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          // Timeout only when the limit is the sole reason for release.
          tmo_d = hold_hit && !done && owner_req && en;
        end else begin
          gnt_d    = gnt_q;
          gnt_id_d = gnt_id_q;
          gs_d     = 1'b1;
          hold_d   = hold_hit ? hold_q : hold_q + 8'd1;
        end
      end
      default: begin
        // RELEASE and the unused encoding drive everything to zero.
      end
    endcase
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign gs     = gs_q;
  assign tmo    = tmo_q;
  assign busy   = (state_q == ST_GRANT) || (state_q == ST_RELEASE);

endmodule
